rm_leds_pr_ctrl: RTL

Controller that sequences the reconfigurable LED module (RM) and the partial-reconfiguration (PR) flow around it. It generates the RM's single-cycle `en` step strobe from a prescaler, and when a PR is requested it quiesces the RM, isolates it with decouple, waits for the PR engine, and then holds the new RM in reset before resuming stepping. It sits in the static region between the PS-side PR request logic and the RM partition pins.

---
 rtl/rm_ctrl_pkg.sv | 15 +
 rtl/rm_tick_gen.sv | 23 ++
 rtl/rm_leds_pr_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/rm_ctrl_pkg.sv
// rm_ctrl_pkg: state codes and fixed timing constants shared by the RM/PR controller.
package rm_ctrl_pkg;

    typedef enum logic [2:0] {
        RM_RST  = 3'd0,
        IDLE    = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        WAIT_PR = 3'd4,
        FAIL    = 3'd5
    } state_t;

    localparam int DRAIN_LEN = 2;

endpackage

// File: rtl/rm_tick_gen.sv
// rm_tick_gen: step prescaler counting 0..DIV-1.
// Ports: clk, reset (sync, active-low), clr (zero the count), hold (freeze the count),
// tick (count is at DIV-1; the count wraps to 0 on the next unheld edge).
module rm_tick_gen #(
    parameter int DIV   = 50_000_000,
    parameter int PRE_W = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    logic [PRE_W-1:0] cnt;

    assign tick = cnt == PRE_W'(DIV - 1);

    always_ff @(posedge clk)
        if (!reset || clr) cnt <= '0;
        else if (!hold) cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/rm_leds_pr_ctrl.sv
// rm_leds_pr_ctrl: steps the LED RM and sequences decouple/reset around partial reconfiguration.
// Ports: clk, reset (sync, active-low), run, pr_req, pr_done, pr_err in;
// rm_en (step strobe), rm_reset, decouple, pr_ack, busy, error, state (debug code) out.
module rm_leds_pr_ctrl
    import rm_ctrl_pkg::*;
#(
    parameter int DIV      = 50_000_000,
    parameter int PRE_W    = 26,
    parameter int RST_HOLD = 16,
    parameter int TIMEOUT  = 2**20,
    parameter int TO_W     = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       pr_req,
    input  logic       pr_done,
    input  logic       pr_err,
    output logic       rm_en,
    output logic       rm_reset,
    output logic       decouple,
    output logic       pr_ack,
    output logic       busy,
    output logic       error,
    output logic [2:0] state
);

    localparam int HW = $clog2(RST_HOLD + 2);

    state_t          st, nxt;
    logic [HW-1:0]   cnt;
    logic [TO_W-1:0] tcnt;
    logic            tick, stay_run, clr;

    // The prescaler only advances on cycles that stay in RUN, so a pr_req or run drop
    // on a terminal count neither strobes nor loses the pending step.
    assign stay_run = st == RUN && nxt == RUN;
    assign clr      = st == RM_RST && nxt != RM_RST;
    assign state    = st;

    rm_tick_gen #(.DIV(DIV), .PRE_W(PRE_W)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .hold  (!stay_run),
        .tick  (tick)
    );

    always_comb begin
        nxt = st;
        case (st)
            RM_RST:  nxt = cnt == HW'(RST_HOLD - 1) ? (run ? RUN : IDLE) : RM_RST;
            IDLE,
            RUN:     nxt = pr_req ? DRAIN : run ? RUN : IDLE;
            DRAIN:   nxt = cnt == HW'(DRAIN_LEN - 1) ? WAIT_PR : DRAIN;
            WAIT_PR: nxt = pr_err ? FAIL : pr_done ? RM_RST : tcnt == TO_W'(TIMEOUT) ? FAIL : WAIT_PR;
            FAIL:    nxt = pr_req ? DRAIN : FAIL;
            default: nxt = RM_RST;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk)
        if (!reset) begin
            st       <= RM_RST;
            cnt      <= '0;
            tcnt     <= '0;
            rm_en    <= 1'b0;
            rm_reset <= 1'b1;
            decouple <= 1'b1;
            pr_ack   <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
        end else begin
            st       <= nxt;
            cnt      <= nxt == st ? cnt + 1'b1 : '0;
            tcnt     <= st == WAIT_PR && nxt == WAIT_PR ? tcnt + 1'b1 : '0;
            rm_en    <= stay_run && tick;
            rm_reset <= nxt == RM_RST || nxt == FAIL;
            decouple <= !(nxt == IDLE || nxt == RUN);
            pr_ack   <= nxt == WAIT_PR;
            busy     <= nxt == DRAIN || nxt == WAIT_PR || (nxt == RM_RST && (st == WAIT_PR || busy));
            error    <= nxt == FAIL;
        end

endmodule
